// File: rtl/mem_port_arbiter_if.sv
// Core/memory bus bundle for mem_port_arbiter.
//   master : arbiter view (takes requests and memory replies; drives responses,
//            stalls and the memory request bus)
//   slave  : environment view (core requesters plus memory model)
//   flush, if_* : fetch requester;  d_* : data requester;  stall_* : pipeline stalls
//   mem_*       : single-ported memory request/response
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_fetch;
    logic              stall_mem;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata, stall_fetch, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata, stall_fetch, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between instruction fetch
// and data load/store. One access is held on the memory bus until mem_ack; read
// data returns to the owner as a one-cycle valid pulse. Round-robin arbitration
// when both stages wait, data first after reset.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mem_port_arbiter_if.master (requests, responses, stalls, memory bus)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    state_t            state;
    gnt_t              last_gnt;
    logic              discard;

    logic              ack;
    logic              done_i;
    logic              done_d;
    logic              drop_i;
    logic              pend_i;
    logic              pend_d;
    logic              arb;
    logic              gnt_i;
    logic              gnt_d;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] rd_word;

    // Arbitration: a requester is pending only while it waits for its own result
    always_comb begin
        ack      = (state != IDLE) && bus.mem_ack;
        done_i   = ack && (state == BUSY_I);
        done_d   = ack && (state == BUSY_D);
        // flushed fetch: its result is thrown away, so if_req now means a new fetch
        drop_i   = discard || bus.flush;
        pend_i   = bus.if_req && !bus.if_valid && !(done_i && !drop_i);
        pend_d   = bus.d_req && !bus.d_valid && !done_d;
        arb      = (state == IDLE) || ack;
        gnt_d    = arb && pend_d && (!pend_i || (last_gnt == GNT_I));
        gnt_i    = arb && pend_i && !gnt_d;
        gnt_addr = gnt_d ? bus.d_addr : bus.if_addr;
        rd_word  = bus.mem_rdata;
    end

    // Stalls follow the request inputs and registered valids only
    assign bus.stall_fetch = bus.if_req & ~bus.if_valid;
    assign bus.stall_mem   = bus.d_req & ~bus.d_valid;

    // Access FSM with registered memory bus and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_gnt      <= GNT_I;
            discard       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_valid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_valid   <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;

            if (done_i) begin
                if (!drop_i) begin
                    bus.if_valid <= 1'b1;
                    bus.if_rdata <= rd_word;
                end
                discard <= 1'b0;
            end else if ((state == BUSY_I) && bus.flush) begin
                discard <= 1'b1;
            end

            if (done_d) begin
                bus.d_valid <= 1'b1;
                if (!bus.mem_we) begin
                    bus.d_rdata <= rd_word;
                end
            end

            if (gnt_d) begin
                state         <= BUSY_D;
                last_gnt      <= GNT_D;
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= gnt_addr;
                bus.mem_wdata <= bus.d_wdata;
            end else if (gnt_i) begin
                state         <= BUSY_I;
                last_gnt      <= GNT_I;
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= gnt_addr;
            end else if (arb) begin
                state       <= IDLE;
                bus.mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected read data is queued per
// requester when a request is issued and checked by a monitor on each valid.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    bit          order_q[$];   // 1 = data valid, 0 = fetch valid

    // Memory model: acks ack_dly cycles after an access appears; rdata = 0x8C010000 | addr>>4
    int unsigned ack_dly = 1;
    int unsigned mcnt;
    logic        m_ack;
    logic        man_ack = 1'b0;
    logic [31:0] m_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt    <= 0;
            m_ack   <= 1'b0;
            m_rdata <= '0;
        end else begin
            m_ack <= 1'b0;
            if (bus.mem_req && !m_ack) begin
                if (mcnt + 1 >= ack_dly) begin
                    m_ack   <= 1'b1;
                    m_rdata <= 32'h8C01_0000 | (bus.mem_addr >> 4);
                    mcnt    <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    assign bus.mem_ack   = m_ack | man_ack;
    assign bus.mem_rdata = m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit is_d, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = is_d ? bus.d_valid : bus.if_valid;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: valid not seen within 40 cycles", name);
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.d_valid === 1'b1) begin
                    order_q.push_back(1'b1);
                    if (exp_d.size() == 0) check("d_valid_unexpected", 32'(bus.d_valid), 32'd0);
                    else                   check("d_rdata", bus.d_rdata, exp_d.pop_front());
                end
                if (bus.if_valid === 1'b1) begin
                    order_q.push_back(1'b0);
                    if (exp_i.size() == 0) check("if_valid_unexpected", 32'(bus.if_valid), 32'd0);
                    else                   check("if_rdata", bus.if_rdata, exp_i.pop_front());
                end
            end
        end
    end

    initial begin
        bit got;
        bus.flush = 1'b0;  bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0;   bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        repeat (3) step();
        check("rst_mem_req",  32'(bus.mem_req),  32'd0);
        check("rst_mem_we",   32'(bus.mem_we),   32'd0);
        check("rst_mem_addr", bus.mem_addr,      32'd0);
        check("rst_mem_wdata", bus.mem_wdata,    32'd0);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_d_valid",  32'(bus.d_valid),  32'd0);
        check("rst_if_rdata", bus.if_rdata,      32'd0);
        check("rst_d_rdata",  bus.d_rdata,       32'd0);
        reset = 1'b0;

        // 1: single fetch, ack one cycle after mem_req
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h40; exp_i.push_back(32'h8C01_0004);
        #1;
        check("t1_stall_t0",   32'(bus.stall_fetch), 32'd1);
        check("t1_mem_req_t0", 32'(bus.mem_req),     32'd0);
        step();
        check("t1_mem_req_t1",  32'(bus.mem_req), 32'd1);
        check("t1_mem_addr_t1", bus.mem_addr,     32'h40);
        check("t1_mem_we_t1",   32'(bus.mem_we),  32'd0);
        step();
        check("t1_if_valid_t2", 32'(bus.if_valid),    32'd0);
        check("t1_stall_t2",    32'(bus.stall_fetch), 32'd1);
        step();
        check("t1_if_valid_t3", 32'(bus.if_valid),    32'd1);
        check("t1_stall_t3",    32'(bus.stall_fetch), 32'd0);
        step();
        bus.if_req = 1'b0;
        check("t1_if_valid_t4", 32'(bus.if_valid), 32'd0);
        check("t1_mem_req_t4",  32'(bus.mem_req),  32'd0);

        // 2: simultaneous fetch and load; data first, fetch granted in data ack cycle
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'h100;
        exp_d.push_back(32'h8C01_0010); exp_i.push_back(32'h8C01_0004);
        step();
        check("t2_mem_req_d",  32'(bus.mem_req), 32'd1);
        check("t2_mem_addr_d", bus.mem_addr,     32'h100);
        step();
        step();
        check("t2_mem_req_i",  32'(bus.mem_req), 32'd1);
        check("t2_mem_addr_i", bus.mem_addr,     32'h44);
        check("t2_d_valid",    32'(bus.d_valid), 32'd1);
        step();
        bus.d_req = 1'b0;
        wait_valid(1'b0, "t2_fetch");
        step();
        bus.if_req = 1'b0;

        // 3: store held until ack; flush during data access has no effect
        ack_dly = 3;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
        exp_d.push_back(32'h8C01_0010);
        step();
        bus.flush = 1'b1;
        check("t3_mem_we",    32'(bus.mem_we), 32'd1);
        check("t3_mem_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
        check("t3_mem_addr",  bus.mem_addr,    32'h200);
        step();
        bus.flush = 1'b0;
        step();
        check("t3_mem_req_hold",   32'(bus.mem_req), 32'd1);
        check("t3_mem_we_hold",    32'(bus.mem_we),  32'd1);
        check("t3_mem_wdata_hold", bus.mem_wdata,    32'hDEAD_BEEF);
        check("t3_d_valid_early",  32'(bus.d_valid), 32'd0);
        wait_valid(1'b1, "t3_store");
        step();
        bus.d_req = 1'b0; bus.d_we = 1'b0;

        // 4: flushed fetch is discarded; new fetch in its ack cycle is granted next cycle
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h60;
        step();
        check("t4_mem_req", 32'(bus.mem_req), 32'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus.mem_ack) got = 1'b1;
            else step();
        end
        check("t4_ack_seen", 32'(got), 32'd1);
        bus.if_addr = 32'h80; exp_i.push_back(32'h8C01_0008);
        step();
        check("t4_if_valid_suppressed", 32'(bus.if_valid), 32'd0);
        check("t4_mem_req_new",  32'(bus.mem_req), 32'd1);
        check("t4_mem_addr_new", bus.mem_addr,     32'h80);
        wait_valid(1'b0, "t4_fetch");
        step();
        bus.if_req = 1'b0;

        // 5: continuous traffic alternates D,I,D,I,D,I
        ack_dly = 1;
        step();
        order_q.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300 + 32'(k) * 32'h10;
                    exp_d.push_back(32'h8C01_0030 + 32'(k));
                    wait_valid(1'b1, "t5_data");
                    step();
                end
                bus.d_req = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    bus.if_req = 1'b1; bus.if_addr = 32'h400 + 32'(k) * 32'h10;
                    exp_i.push_back(32'h8C01_0040 + 32'(k));
                    wait_valid(1'b0, "t5_fetch");
                    step();
                end
                bus.if_req = 1'b0;
            end
        join
        check("t5_valid_count", 32'(order_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < order_q.size(); i++) begin
            bit exp_b;
            exp_b = (i % 2 == 0);
            check($sformatf("t5_order_%0d", i), 32'(order_q[i]), 32'(exp_b));
        end

        // 6: reset mid-access abandons it; late ack afterwards is ignored
        ack_dly = 100;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        step();
        check("t6_mem_req_busy", 32'(bus.mem_req), 32'd1);
        step();
        #2;
        reset = 1'b1;
        #1;
        check("t6_mem_req_async", 32'(bus.mem_req), 32'd0);
        check("t6_d_valid_async", 32'(bus.d_valid), 32'd0);
        check("t6_mem_addr_async", bus.mem_addr,     32'd0);
        bus.d_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        ack_dly = 1;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("t6_late_ack_d_valid", 32'(bus.d_valid),  32'd0);
        check("t6_late_ack_if_valid", 32'(bus.if_valid), 32'd0);
        check("t6_late_ack_mem_req", 32'(bus.mem_req),  32'd0);
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h40; exp_i.push_back(32'h8C01_0004);
        step();
        check("t6_fresh_mem_req",  32'(bus.mem_req), 32'd1);
        check("t6_fresh_mem_addr", bus.mem_addr,     32'h40);
        wait_valid(1'b0, "t6_fetch");
        step();
        bus.if_req = 1'b0;

        repeat (3) step();
        check("exp_i_drained", 32'(exp_i.size()), 32'd0);
        check("exp_d_drained", 32'(exp_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
